// File: rtl/pig_impulse_scheduler.sv
// Per-frame round-robin scheduler that hands one bird impact impulse to one pig per frame.
// Define PIG_IMPULSE_SAT_EN to clamp each latched impulse component to +/-MAX_FORCE.
module pig_impulse_scheduler #(
  parameter int NUM_PIGS    = 4,
  parameter int FORCE_SHIFT = 1,
  parameter int CD_FRAMES   = 15
`ifdef PIG_IMPULSE_SAT_EN
  ,
  parameter logic signed [16:0] MAX_FORCE = 17'sd2048
`endif
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       vsync,
  input  logic [1:0]                 game_state,
  input  logic [NUM_PIGS-1:0]        hit_req,
  input  logic signed [16:0]         bird_vx,
  input  logic signed [16:0]         bird_vy,
  output logic [17*NUM_PIGS-1:0]     pig_force_x,
  output logic [17*NUM_PIGS-1:0]     pig_force_y,
  output logic [NUM_PIGS-1:0]        grant,
  output logic                       bird_hit,
  output logic                       busy
);

  localparam int PTR_W = (NUM_PIGS > 1) ? $clog2(NUM_PIGS) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DRIVE} state_t;

  state_t              state, state_nxt;
  logic [NUM_PIGS-1:0] pending, pending_nxt;
  logic [3:0]          cooldown [NUM_PIGS];
  logic [PTR_W-1:0]    rr_ptr, win_idx, scan_idx;
  logic                scan_found;
  logic signed [16:0]  fx, fy;
  logic                first_drive;
  logic                flush;
  logic                drive_end;

  assign flush     = (game_state == 2'd0);
  assign drive_end = (state == DRIVE) && vsync;

  function automatic logic signed [16:0] scale_impulse(input logic signed [16:0] v);
    logic signed [16:0] s;
    s = v >>> FORCE_SHIFT;
`ifdef PIG_IMPULSE_SAT_EN
    if (s > MAX_FORCE)
      s = MAX_FORCE;
    else if (s < -MAX_FORCE)
      s = -MAX_FORCE;
`endif
    return s;
  endfunction

  // First pending pig at or after rr_ptr, wrapping around the slot count
  always_comb begin
    int idx;
    scan_found = 1'b0;
    scan_idx   = '0;
    idx        = 0;
    for (int k = 0; k < NUM_PIGS; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_PIGS)
        idx = idx - NUM_PIGS;
      if (!scan_found && pending[idx]) begin
        scan_found = 1'b1;
        scan_idx   = PTR_W'(idx);
      end
    end
  end

  // The pig being scanned or driven is masked so a held request cannot re-arm it before its cooldown loads
  always_comb begin
    pending_nxt = pending;
    for (int i = 0; i < NUM_PIGS; i++) begin
      if (hit_req[i] && (cooldown[i] == 4'd0))
        pending_nxt[i] = 1'b1;
    end
    if (state == SCAN && scan_found)
      pending_nxt[scan_idx] = 1'b0;
    if (state == DRIVE)
      pending_nxt[win_idx] = 1'b0;
    if (flush)
      pending_nxt = '0;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (vsync && (pending != '0)) state_nxt = SCAN;
      SCAN:    state_nxt = scan_found ? DRIVE : IDLE;
      DRIVE:   if (vsync) state_nxt = (pending_nxt != '0) ? SCAN : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush)
      state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      pending     <= '0;
      rr_ptr      <= '0;
      win_idx     <= '0;
      fx          <= '0;
      fy          <= '0;
      first_drive <= 1'b0;
    end else begin
      state       <= state_nxt;
      pending     <= pending_nxt;
      first_drive <= (state == SCAN) && (state_nxt == DRIVE);
      if (state == SCAN && scan_found && !flush) begin
        win_idx <= scan_idx;
        rr_ptr  <= (scan_idx == PTR_W'(NUM_PIGS - 1)) ? '0 : scan_idx + 1'b1;
        fx      <= scale_impulse(bird_vx);
        fy      <= scale_impulse(bird_vy);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_PIGS; i++)
        cooldown[i] <= 4'd0;
    end else begin
      for (int i = 0; i < NUM_PIGS; i++) begin
        if (flush)
          cooldown[i] <= 4'd0;
        else if (drive_end && (win_idx == PTR_W'(i)))
          cooldown[i] <= 4'(CD_FRAMES);
        else if (vsync && (cooldown[i] != 4'd0))
          cooldown[i] <= cooldown[i] - 4'd1;
      end
    end
  end

  // Outputs decode from state so an async reset clears them without a clock edge
  always_comb begin
    pig_force_x = '0;
    pig_force_y = '0;
    grant       = '0;
    bird_hit    = 1'b0;
    busy        = (state != IDLE);
    if (state == DRIVE) begin
      grant[win_idx]                        = 1'b1;
      pig_force_x[17*int'(win_idx) +: 17]   = fx;
      pig_force_y[17*int'(win_idx) +: 17]   = fy;
      bird_hit                              = first_drive;
    end
  end

endmodule

// File: tb/tb_pig_impulse_scheduler.sv
// Directed bench for pig_impulse_scheduler: grant timing, round-robin, cooldown, flush, async reset, saturation.
module tb_pig_impulse_scheduler;

  localparam int N = 4;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  vsync = 1'b0;
  logic [1:0]            game_state = 2'd1;
  logic [N-1:0]          hit_req = '0;
  logic signed [16:0]    bird_vx = '0;
  logic signed [16:0]    bird_vy = '0;
  logic [17*N-1:0]       pig_force_x;
  logic [17*N-1:0]       pig_force_y;
  logic [N-1:0]          grant;
  logic                  bird_hit;
  logic                  busy;

  int checks = 0;
  int errors = 0;
  logic signed [16:0] exp_fx, exp_fy;

  pig_impulse_scheduler #(.NUM_PIGS(N), .FORCE_SHIFT(1), .CD_FRAMES(15)) dut (
    .clk(clk), .rst(rst), .vsync(vsync), .game_state(game_state),
    .hit_req(hit_req), .bird_vx(bird_vx), .bird_vy(bird_vy),
    .pig_force_x(pig_force_x), .pig_force_y(pig_force_y),
    .grant(grant), .bird_hit(bird_hit), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] slot_x(input int i);
    return pig_force_x[17*i +: 17];
  endfunction

  function automatic logic [16:0] slot_y(input int i);
    return pig_force_y[17*i +: 17];
  endfunction

  task automatic checkOutput(input string tag, input logic [16:0] observed, input logic [16:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one clock of stimulus; vsync falls afterwards, hit_req keeps its value
  task automatic applyStimulus(input logic [N-1:0] req, input logic vs);
    hit_req = req;
    vsync   = vs;
    tick();
    vsync   = 1'b0;
  endtask

  initial begin
`ifdef PIG_IMPULSE_SAT_EN
    exp_fx = 17'sd2048;
    exp_fy = -17'sd2048;
`else
    exp_fx = 17'sd4000;
    exp_fy = -17'sd5000;
`endif

    #12;
    checkOutput("reset_grant", 17'(grant), 17'd0);
    checkOutput("reset_bird_hit", 17'(bird_hit), 17'd0);
    checkOutput("reset_busy", 17'(busy), 17'd0);
    checkOutput("reset_forces", 17'(|{pig_force_x, pig_force_y}), 17'd0);
    rst = 1'b1;

    // Single request to pig 2
    bird_vx = 17'sd640;
    bird_vy = -17'sd320;
    applyStimulus(4'b0100, 1'b0);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("t1_scan_busy", 17'(busy), 17'd1);
    checkOutput("t1_scan_grant", 17'(grant), 17'd0);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("t1_grant", 17'(grant), 17'b0100);
    checkOutput("t1_bird_hit", 17'(bird_hit), 17'd1);
    checkOutput("t1_slot2_x", slot_x(2), 17'd320);
    checkOutput("t1_slot2_y", slot_y(2), 17'h1FF60);
    checkOutput("t1_slot0_x", slot_x(0), 17'd0);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("t1_bird_hit_once", 17'(bird_hit), 17'd0);
    checkOutput("t1_grant_hold", 17'(grant), 17'b0100);
    vsync = 1'b1;
    #3;
    checkOutput("t1_vsync_still_driven", slot_x(2), 17'd320);
    tick();
    vsync = 1'b0;
    checkOutput("t1_grant_cleared", 17'(grant), 17'd0);
    checkOutput("t1_slot_cleared", slot_x(2), 17'd0);
    checkOutput("t1_idle", 17'(busy), 17'd0);

    // Pig 2 cooling down: blocked for 15 vsyncs, served right after
    applyStimulus(4'b0100, 1'b0);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("t3_cooldown_block", 17'(busy), 17'd0);
    repeat (13) applyStimulus(4'b0000, 1'b1);
    applyStimulus(4'b0100, 1'b0);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("t3_cooldown_last_frame", 17'(busy), 17'd0);
    applyStimulus(4'b0100, 1'b0);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("t3_after_cooldown_scan", 17'(busy), 17'd1);
    bird_vx = -17'sd1000;
    bird_vy = -17'sd7;
    applyStimulus(4'b0000, 1'b0);
    checkOutput("t3_regrant", 17'(grant), 17'b0100);
    checkOutput("t3_neg_x", slot_x(2), 17'h1FE0C);
    checkOutput("t3_neg_odd_y", slot_y(2), 17'h1FFFC);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("t3_end", 17'(grant), 17'd0);

    // Fresh reset so rr_ptr starts at 0; all pigs request continuously
    #3 rst = 1'b0;
    #2 rst = 1'b1;
    bird_vx = 17'sd100;
    bird_vy = 17'sd60;
    applyStimulus(4'b1111, 1'b0);
    applyStimulus(4'b1111, 1'b1);
    for (int g = 0; g < N; g++) begin
      if (g == 3) begin
        bird_vx = '0;
        bird_vy = '0;
      end
      checkOutput("t2_scan_busy", 17'(busy), 17'd1);
      applyStimulus(4'b1111, 1'b0);
      checkOutput("t2_rr_grant", 17'(grant), 17'(1 << g));
      checkOutput("t2_bird_hit", 17'(bird_hit), 17'd1);
      checkOutput("t2_force_x", slot_x(g), (g == 3) ? 17'd0 : 17'd50);
      checkOutput("t2_force_y", slot_y(g), (g == 3) ? 17'd0 : 17'd30);
      applyStimulus(4'b1111, 1'b0);
      applyStimulus(4'b1111, 1'b0);
      applyStimulus(4'b1111, 1'b1);
    end
    checkOutput("t2_all_cooling", 17'(busy), 17'd0);
    for (int f = 0; f < 12; f++) begin
      applyStimulus(4'b1111, 1'b1);
      checkOutput("t2_pig0_cooling", 17'(busy), 17'd0);
    end
    applyStimulus(4'b1111, 1'b0);
    applyStimulus(4'b1111, 1'b1);
    checkOutput("t2_pig0_scan", 17'(busy), 17'd1);
    bird_vx = 17'sd8000;
    bird_vy = -17'sd10000;
    applyStimulus(4'b1111, 1'b0);
    checkOutput("t2_pig0_regrant", 17'(grant), 17'b0001);
    checkOutput("t6_sat_x", slot_x(0), exp_fx);
    checkOutput("t6_sat_y", slot_y(0), exp_fy);

    // Flush during DRIVE
    game_state = 2'd0;
    applyStimulus(4'b1111, 1'b0);
    checkOutput("t4_flush_grant", 17'(grant), 17'd0);
    checkOutput("t4_flush_busy", 17'(busy), 17'd0);
    checkOutput("t4_flush_forces", 17'(|{pig_force_x, pig_force_y}), 17'd0);
    game_state = 2'd1;
    applyStimulus(4'b0000, 1'b1);
    checkOutput("t4_pending_flushed", 17'(busy), 17'd0);
    applyStimulus(4'b1111, 1'b0);
    applyStimulus(4'b0000, 1'b1);
    bird_vx = 17'sd200;
    bird_vy = -17'sd100;
    applyStimulus(4'b0000, 1'b0);
    checkOutput("t4_rr_ptr_kept", 17'(grant), 17'b0010);
    checkOutput("t4_force_x", slot_x(1), 17'd100);

    // Asynchronous reset in the middle of a clock period
    #3 rst = 1'b0;
    #1;
    checkOutput("t5_async_grant", 17'(grant), 17'd0);
    checkOutput("t5_async_forces", 17'(|{pig_force_x, pig_force_y}), 17'd0);
    checkOutput("t5_async_busy", 17'(busy), 17'd0);
    #2 rst = 1'b1;
    tick();
    checkOutput("t5_after_release", 17'(grant), 17'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
